// File: rtl/regfile_scan_reader.sv
// Read-side sequencer that walks a 2**D x W register file and streams (addr, data) beats.
// Optional checksum of the streamed data is built only when REGFILE_SCAN_CSUM_EN is defined.
module regfile_scan_reader #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         hold,
  output logic [D-1:0] read_addr,
  input  logic [W-1:0] rd_data,
  output logic [D-1:0] dump_addr,
  output logic [W-1:0] dump_data,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] csum
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  // One extra index bit keeps the last address distinct from a wrapped zero.
  localparam logic [D:0] LAST = {1'b0, {D{1'b1}}};
  localparam logic [D:0] ONE  = {{D{1'b0}}, 1'b1};

  state_t     state;
  state_t     state_next;
  logic [D:0] index;
  logic       accept;

  assign accept = (state == SEND) && dump_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = READ;
      READ: if (!hold) state_next = SEND;
      SEND: if (dump_ready) state_next = (index == LAST) ? DONE : READ;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index     <= '0;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) index <= '0;
        READ: begin
          if (!hold) begin
            dump_addr <= index[D-1:0];
            dump_data <= rd_data;
          end
        end
        SEND: if (dump_ready && (index != LAST)) index <= index + ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    read_addr  = '0;
    dump_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      READ: read_addr = index[D-1:0];
      SEND: begin
        read_addr  = index[D-1:0];
        dump_valid = 1'b1;
      end
      DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

`ifdef REGFILE_SCAN_CSUM_EN
  // Accumulates only on accepted beats, so the sum holds steady from done until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if ((state == IDLE) && start) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum + dump_data;
    end
  end
`else
  assign csum = '0;
`endif

endmodule
